// File: rtl/niu_sii_pkg.sv
// Shared types, constants and the lane-parity helper for the NIU->SII request transmitter.
package niu_sii_pkg;

  localparam int PLD_BEATS = 4;
  localparam int HDR_W     = 128;
  localparam int PAR_W     = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAITCR,
    HDR,
    PLD
  } state_t;

  // Odd parity over each 16-bit lane of a header/payload word
  function automatic logic [PAR_W-1:0] lane_parity(input logic [HDR_W-1:0] d);
    logic [PAR_W-1:0] p;
    for (int i = 0; i < PAR_W; i++) begin
      p[i] = ~^d[16*i +: 16];
    end
    return p;
  endfunction

endpackage

// File: rtl/niu_sii_credit_ctr.sv
// Credit counter for one SII queue; starts full, counts frees up and issues down.
module niu_sii_credit_ctr #(
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input  logic          iol2clk,
  input  logic          rst_l,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] avail,
  output logic          err
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] r_avail;
  logic          r_err;

  // A free arriving with the counter already full is dropped and flagged until reset
  always_ff @(posedge iol2clk) begin
    if (!rst_l) begin
      r_avail <= FULL;
      r_err   <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (r_avail == FULL) r_err <= 1'b1;
          else                 r_avail <= r_avail + CW'(1);
        end
        2'b01:   r_avail <= r_avail - CW'(1);
        default: r_avail <= r_avail;
      endcase
    end
  end

  assign avail = r_avail;
  assign err   = r_err;

endmodule

// File: rtl/niu_sii_req_tx.sv
// Driving end of the niu_sii header/payload request interface: buffers a full write
// payload, then issues header (+4 payload beats) once the target queue has credit.
module niu_sii_req_tx
  import niu_sii_pkg::*;
#(
  parameter int OQ_DEPTH = 16,
  parameter int BQ_DEPTH = 16,
  parameter int CW       = 5
) (
  input  logic             iol2clk,
  input  logic             rst_l,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic             req_wr,
  input  logic             req_byp,
  input  logic [HDR_W-1:0] req_hdr,
  input  logic [15:0]      req_be,
  input  logic             pld_vld,
  output logic             pld_rdy,
  input  logic [HDR_W-1:0] pld_data,
  output logic             niu_sii_hdr_vld,
  output logic             niu_sii_reqbypass,
  output logic             niu_sii_datareq,
  output logic             niu_sii_datareq16,
  output logic [HDR_W-1:0] niu_sii_data,
  output logic [PAR_W-1:0] niu_sii_parity,
  output logic [15:0]      niu_sii_be,
  input  logic             sii_niu_oqdq,
  input  logic             sii_niu_bqdq,
  output logic             credit_err
);

  state_t           r_state, w_next;
  logic             r_wr, r_byp;
  logic [HDR_W-1:0] r_hdr;
  logic [15:0]      r_be;
  logic [HDR_W-1:0] r_buf [PLD_BEATS];
  logic [1:0]       r_beat;
  logic             r_hdr_vld, r_pld_vld, r_reqbyp, r_datareq;
  logic [HDR_W-1:0] r_data;
  logic [15:0]      r_obe;
  logic [CW-1:0]    w_oq_avail, w_bq_avail;
  logic             w_oq_err, w_bq_err;
  logic             w_pld_take, w_in_hdr, w_cr_ok;
  logic             w_nx_hdr, w_nx_pld;
  logic [1:0]       w_pld_idx;

  assign req_rdy    = (r_state == IDLE);
  assign pld_rdy    = (r_state == LOAD);
  assign w_pld_take = pld_vld & pld_rdy;
  assign w_in_hdr   = (r_state == HDR);
  // A free landing in the same cycle as a zero credit still lets the header go next
  assign w_cr_ok    = r_byp ? ((w_bq_avail != '0) | sii_niu_bqdq)
                            : ((w_oq_avail != '0) | sii_niu_oqdq);

  niu_sii_credit_ctr #(.DEPTH(OQ_DEPTH), .CW(CW)) u_oq (
    .iol2clk(iol2clk), .rst_l(rst_l), .inc(sii_niu_oqdq), .dec(w_in_hdr & ~r_byp),
    .avail(w_oq_avail), .err(w_oq_err)
  );

  niu_sii_credit_ctr #(.DEPTH(BQ_DEPTH), .CW(CW)) u_bq (
    .iol2clk(iol2clk), .rst_l(rst_l), .inc(sii_niu_bqdq), .dec(w_in_hdr & r_byp),
    .avail(w_bq_avail), .err(w_bq_err)
  );

  assign credit_err = w_oq_err | w_bq_err;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_vld) w_next = req_wr ? LOAD : WAITCR;
      LOAD:    if (w_pld_take && r_beat == 2'd3) w_next = WAITCR;
      WAITCR:  if (w_cr_ok) w_next = HDR;
      HDR:     w_next = r_wr ? PLD : IDLE;
      PLD:     if (r_beat == 2'd3) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output registers load from the next state so the header leaves two cycles after acceptance
  assign w_nx_hdr  = (w_next == HDR);
  assign w_nx_pld  = (w_next == PLD);
  assign w_pld_idx = (r_state == PLD) ? r_beat + 2'd1 : 2'd0;

  always_ff @(posedge iol2clk) begin
    if (!rst_l) begin
      r_state   <= IDLE;
      r_wr      <= 1'b0;
      r_byp     <= 1'b0;
      r_hdr     <= '0;
      r_be      <= '0;
      r_beat    <= 2'd0;
      r_hdr_vld <= 1'b0;
      r_pld_vld <= 1'b0;
      r_reqbyp  <= 1'b0;
      r_datareq <= 1'b0;
      r_data    <= '0;
      r_obe     <= '0;
    end else begin
      r_state <= w_next;
      if (req_rdy && req_vld) begin
        r_wr  <= req_wr;
        r_byp <= req_byp;
        r_hdr <= req_hdr;
        r_be  <= req_be;
      end
      if (w_pld_take || r_state == PLD) r_beat <= r_beat + 2'd1;
      r_hdr_vld <= w_nx_hdr;
      r_pld_vld <= w_nx_pld;
      r_reqbyp  <= w_nx_hdr & r_byp;
      r_datareq <= w_nx_hdr & r_wr;
      r_obe     <= w_nx_hdr ? r_be : '0;
      r_data    <= w_nx_hdr ? r_hdr : (w_nx_pld ? r_buf[w_pld_idx] : '0);
    end
  end

  always_ff @(posedge iol2clk) begin
    if (w_pld_take) r_buf[r_beat] <= pld_data;
  end

  assign niu_sii_hdr_vld   = r_hdr_vld;
  assign niu_sii_reqbypass = r_reqbyp;
  assign niu_sii_datareq   = r_datareq;
  assign niu_sii_datareq16 = 1'b0;
  assign niu_sii_data      = r_data;
  assign niu_sii_be        = r_obe;
  assign niu_sii_parity    = (r_hdr_vld | r_pld_vld) ? lane_parity(r_data) : '0;

endmodule

// File: tb/tb_niu_sii_req_tx.sv
// Self-checking bench for niu_sii_req_tx: directed scenarios plus randomized traffic
// checked against a transaction-level credit/parity model.
module tb_niu_sii_req_tx;

  localparam int DEPTH = 16;

  logic         iol2clk = 1'b0;
  logic         rst_l, req_vld, req_rdy, req_wr, req_byp;
  logic [127:0] req_hdr, pld_data, niu_sii_data;
  logic [15:0]  req_be, niu_sii_be;
  logic         pld_vld, pld_rdy;
  logic         niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq, niu_sii_datareq16;
  logic [7:0]   niu_sii_parity;
  logic         sii_niu_oqdq, sii_niu_bqdq, credit_err;

  int passCnt  = 0;
  int totalCnt = 0;
  int mOq, mBq;
  bit mErr;

  always #5 iol2clk = ~iol2clk;

  niu_sii_req_tx #(.OQ_DEPTH(DEPTH), .BQ_DEPTH(DEPTH), .CW(5)) dut (
    .iol2clk(iol2clk), .rst_l(rst_l), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_wr(req_wr), .req_byp(req_byp), .req_hdr(req_hdr), .req_be(req_be),
    .pld_vld(pld_vld), .pld_rdy(pld_rdy), .pld_data(pld_data),
    .niu_sii_hdr_vld(niu_sii_hdr_vld), .niu_sii_reqbypass(niu_sii_reqbypass),
    .niu_sii_datareq(niu_sii_datareq), .niu_sii_datareq16(niu_sii_datareq16),
    .niu_sii_data(niu_sii_data), .niu_sii_parity(niu_sii_parity), .niu_sii_be(niu_sii_be),
    .sii_niu_oqdq(sii_niu_oqdq), .sii_niu_bqdq(sii_niu_bqdq), .credit_err(credit_err)
  );

  // Expected parity: a lane bit is 1 when the lane holds an even number of ones
  function automatic logic [7:0] modelPar(input logic [127:0] d);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = (($countones(d[i*16 +: 16]) % 2) == 0);
    return p;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge iol2clk);
    #1;
  endtask

  task automatic applyReset();
    rst_l = 1'b0;
    req_vld = 1'b0; req_wr = 1'b0; req_byp = 1'b0; req_hdr = '0; req_be = '0;
    pld_vld = 1'b0; pld_data = '0; sii_niu_oqdq = 1'b0; sii_niu_bqdq = 1'b0;
    tick();
    tick();
    rst_l = 1'b1;
    mOq = DEPTH; mBq = DEPTH; mErr = 1'b0;
  endtask

  // Hands one request to the DUT; returns right after the accepting edge (read) or last beat edge (write)
  task automatic issueReq(input bit wr, input bit byp, input logic [127:0] hdr, input logic [15:0] be,
                          input logic [3:0][127:0] beats, input int gap, output bit ok);
    int n;
    ok = 1'b0;
    for (n = 0; n < 50 && !req_rdy; n++) tick();
    if (!req_rdy) return;
    req_vld = 1'b1; req_wr = wr; req_byp = byp; req_hdr = hdr; req_be = be;
    tick();
    req_vld = 1'b0; req_wr = 1'b0; req_byp = 1'b0; req_hdr = '0; req_be = '0;
    if (wr) begin
      for (int k = 0; k < 4; k++) begin
        repeat (gap) tick();
        pld_vld = 1'b1; pld_data = beats[k];
        for (n = 0; n < 20 && !pld_rdy; n++) tick();
        if (!pld_rdy) begin pld_vld = 1'b0; return; end
        tick();
        pld_vld = 1'b0; pld_data = '0;
      end
    end
    ok = 1'b1;
  endtask

  task automatic pulseDq(input bit byp);
    if (byp) sii_niu_bqdq = 1'b1; else sii_niu_oqdq = 1'b1;
    tick();
    sii_niu_bqdq = 1'b0; sii_niu_oqdq = 1'b0;
    if (byp) begin if (mBq == DEPTH) mErr = 1'b1; else mBq++; end
    else     begin if (mOq == DEPTH) mErr = 1'b1; else mOq++; end
  endtask

  task automatic test_reset();
    applyReset();
    totalCnt++; if ({niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq, niu_sii_datareq16, credit_err, pld_rdy, req_rdy} !== 7'b0000001)
      $display("[TB] FAIL reset_ctl: got %b want 0000001", {niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq, niu_sii_datareq16, credit_err, pld_rdy, req_rdy}); else passCnt++;
    totalCnt++; if (niu_sii_data !== '0) $display("[TB] FAIL reset_data: got %h want 0", niu_sii_data); else passCnt++;
    totalCnt++; if ({niu_sii_parity, niu_sii_be} !== 24'h0) $display("[TB] FAIL reset_par_be: got %h want 0", {niu_sii_parity, niu_sii_be}); else passCnt++;
    totalCnt++; if (dut.u_oq.avail !== 5'(DEPTH)) $display("[TB] FAIL reset_oq_cr: got %0d want %0d", dut.u_oq.avail, DEPTH); else passCnt++;
    totalCnt++; if (dut.u_bq.avail !== 5'(DEPTH)) $display("[TB] FAIL reset_bq_cr: got %0d want %0d", dut.u_bq.avail, DEPTH); else passCnt++;
  endtask

  task automatic test_read();
    bit ok;
    logic [127:0] hdr = {8{16'hA5A5}};
    issueReq(1'b0, 1'b0, hdr, 16'hFFFF, '0, 0, ok);
    totalCnt++; if (!ok) $display("[TB] FAIL read_accept: got timeout want accepted"); else passCnt++;
    tick();
    totalCnt++; if ({niu_sii_hdr_vld, niu_sii_datareq, niu_sii_reqbypass} !== 3'b100)
      $display("[TB] FAIL read_hdr_ctl: got %b want 100", {niu_sii_hdr_vld, niu_sii_datareq, niu_sii_reqbypass}); else passCnt++;
    totalCnt++; if (niu_sii_data !== hdr) $display("[TB] FAIL read_hdr_data: got %h want %h", niu_sii_data, hdr); else passCnt++;
    totalCnt++; if (niu_sii_parity !== modelPar(hdr)) $display("[TB] FAIL read_parity: got %h want %h", niu_sii_parity, modelPar(hdr)); else passCnt++;
    totalCnt++; if (niu_sii_be !== 16'hFFFF) $display("[TB] FAIL read_be: got %h want ffff", niu_sii_be); else passCnt++;
    tick();
    mOq--;
    totalCnt++; if (dut.u_oq.avail !== 5'(mOq)) $display("[TB] FAIL read_oq_cr: got %0d want %0d", dut.u_oq.avail, mOq); else passCnt++;
    totalCnt++; if ({niu_sii_hdr_vld, niu_sii_data} !== '0) $display("[TB] FAIL read_after: got %b/%h want 0/0", niu_sii_hdr_vld, niu_sii_data); else passCnt++;
  endtask

  task automatic test_write();
    bit ok;
    logic [3:0][127:0] beats;
    logic [127:0] hdr = rand128();
    for (int k = 0; k < 4; k++) beats[k] = 128'(k + 1);
    issueReq(1'b1, 1'b1, hdr, 16'h0F0F, beats, 3, ok);
    totalCnt++; if (!ok) $display("[TB] FAIL write_accept: got timeout want accepted"); else passCnt++;
    tick();
    totalCnt++; if ({niu_sii_hdr_vld, niu_sii_datareq, niu_sii_reqbypass} !== 3'b111)
      $display("[TB] FAIL write_hdr_ctl: got %b want 111", {niu_sii_hdr_vld, niu_sii_datareq, niu_sii_reqbypass}); else passCnt++;
    totalCnt++; if ({niu_sii_data, niu_sii_be} !== {hdr, 16'h0F0F}) $display("[TB] FAIL write_hdr_data: got %h want %h", {niu_sii_data, niu_sii_be}, {hdr, 16'h0F0F}); else passCnt++;
    for (int k = 0; k < 4; k++) begin
      tick();
      totalCnt++; if ({niu_sii_hdr_vld, niu_sii_datareq, niu_sii_data} !== {2'b00, beats[k]})
        $display("[TB] FAIL write_beat%0d: got %b%b/%h want 00/%h", k, niu_sii_hdr_vld, niu_sii_datareq, niu_sii_data, beats[k]); else passCnt++;
      totalCnt++; if (niu_sii_parity !== modelPar(beats[k])) $display("[TB] FAIL write_par%0d: got %h want %h", k, niu_sii_parity, modelPar(beats[k])); else passCnt++;
    end
    tick();
    mBq--;
    totalCnt++; if ({niu_sii_hdr_vld, niu_sii_data, niu_sii_parity} !== '0) $display("[TB] FAIL write_tail: got %h want 0", niu_sii_data); else passCnt++;
    totalCnt++; if (dut.u_bq.avail !== 5'(mBq)) $display("[TB] FAIL write_bq_cr: got %0d want %0d", dut.u_bq.avail, mBq); else passCnt++;
  endtask

  task automatic test_credit_stall();
    bit ok;
    int hdrs = 0;
    int stray = 0;
    applyReset();
    for (int i = 0; i < DEPTH; i++) begin
      issueReq(1'b0, 1'b0, rand128(), 16'hFFFF, '0, 0, ok);
      tick();
      if (ok && niu_sii_hdr_vld) hdrs++;
      mOq--;
    end
    totalCnt++; if (hdrs != DEPTH) $display("[TB] FAIL stall_hdr_cnt: got %0d want %0d", hdrs, DEPTH); else passCnt++;
    issueReq(1'b0, 1'b0, 128'h1234, 16'h00FF, '0, 0, ok);
    totalCnt++; if (!ok) $display("[TB] FAIL stall_accept: got timeout want accepted"); else passCnt++;
    repeat (6) begin tick(); if (niu_sii_hdr_vld) stray++; end
    totalCnt++; if (stray != 0) $display("[TB] FAIL stall_no_hdr: got %0d want 0", stray); else passCnt++;
    sii_niu_oqdq = 1'b1;
    tick();
    sii_niu_oqdq = 1'b0;
    totalCnt++; if ({niu_sii_hdr_vld, niu_sii_data} !== {1'b1, 128'h1234}) $display("[TB] FAIL stall_release: got %b/%h want 1/1234", niu_sii_hdr_vld, niu_sii_data); else passCnt++;
    tick();
    totalCnt++; if (dut.u_oq.avail !== 5'(mOq)) $display("[TB] FAIL stall_oq_cr: got %0d want %0d", dut.u_oq.avail, mOq); else passCnt++;
  endtask

  task automatic test_simultaneous();
    bit ok;
    repeat (5) pulseDq(1'b0);
    totalCnt++; if (dut.u_oq.avail !== 5'(mOq)) $display("[TB] FAIL simul_pre_cr: got %0d want %0d", dut.u_oq.avail, mOq); else passCnt++;
    issueReq(1'b0, 1'b0, rand128(), 16'h1111, '0, 0, ok);
    tick();
    totalCnt++; if (!ok || niu_sii_hdr_vld !== 1'b1) $display("[TB] FAIL simul_hdr: got %b want 1", niu_sii_hdr_vld); else passCnt++;
    sii_niu_oqdq = 1'b1;
    tick();
    sii_niu_oqdq = 1'b0;
    totalCnt++; if (dut.u_oq.avail !== 5'(mOq)) $display("[TB] FAIL simul_cr: got %0d want %0d", dut.u_oq.avail, mOq); else passCnt++;
    totalCnt++; if (credit_err !== 1'b0) $display("[TB] FAIL simul_err: got %b want 0", credit_err); else passCnt++;
  endtask

  task automatic test_credit_err();
    pulseDq(1'b1);
    totalCnt++; if (credit_err !== mErr) $display("[TB] FAIL err_set: got %b want %b", credit_err, mErr); else passCnt++;
    totalCnt++; if (dut.u_bq.avail !== 5'(mBq)) $display("[TB] FAIL err_bq_cr: got %0d want %0d", dut.u_bq.avail, mBq); else passCnt++;
    repeat (4) tick();
    totalCnt++; if (credit_err !== mErr) $display("[TB] FAIL err_sticky: got %b want %b", credit_err, mErr); else passCnt++;
  endtask

  task automatic test_random();
    bit ok, wr, byp;
    logic [127:0] hdr;
    logic [15:0] be;
    logic [3:0][127:0] beats;
    for (int t = 0; t < 24; t++) begin
      wr = 1'($urandom); byp = 1'($urandom);
      hdr = rand128(); be = 16'($urandom);
      for (int k = 0; k < 4; k++) beats[k] = rand128();
      if ($urandom_range(0, 3) == 0) pulseDq(1'($urandom));
      if (byp ? (mBq == 0) : (mOq == 0)) pulseDq(byp);
      issueReq(wr, byp, hdr, be, beats, $urandom_range(0, 2), ok);
      tick();
      totalCnt++; if (!ok || {niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq} !== {1'b1, byp, wr})
        $display("[TB] FAIL rnd%0d_hdr_ctl: got %b want %b", t, {niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq}, {1'b1, byp, wr}); else passCnt++;
      totalCnt++; if ({niu_sii_data, niu_sii_be, niu_sii_parity} !== {hdr, be, modelPar(hdr)})
        $display("[TB] FAIL rnd%0d_hdr: got %h want %h", t, {niu_sii_data, niu_sii_be, niu_sii_parity}, {hdr, be, modelPar(hdr)}); else passCnt++;
      if (byp) mBq--; else mOq--;
      if (wr) begin
        for (int k = 0; k < 4; k++) begin
          tick();
          totalCnt++; if ({niu_sii_hdr_vld, niu_sii_datareq, niu_sii_data, niu_sii_parity} !== {2'b00, beats[k], modelPar(beats[k])})
            $display("[TB] FAIL rnd%0d_beat%0d: got %h/%h want %h/%h", t, k, niu_sii_data, niu_sii_parity, beats[k], modelPar(beats[k])); else passCnt++;
        end
      end
    end
    tick();
    totalCnt++; if ({dut.u_oq.avail, dut.u_bq.avail} !== {5'(mOq), 5'(mBq)})
      $display("[TB] FAIL rnd_credits: got %0d/%0d want %0d/%0d", dut.u_oq.avail, dut.u_bq.avail, mOq, mBq); else passCnt++;
    totalCnt++; if (credit_err !== mErr) $display("[TB] FAIL rnd_err: got %b want %b", credit_err, mErr); else passCnt++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int stray = 0;
    logic [3:0][127:0] beats;
    for (int k = 0; k < 4; k++) beats[k] = rand128() | 128'h1;
    if (mOq == 0) pulseDq(1'b0);
    issueReq(1'b1, 1'b0, rand128(), 16'hFFFF, beats, 0, ok);
    repeat (4) tick();
    totalCnt++; if (!ok || niu_sii_data !== beats[2]) $display("[TB] FAIL mid_beat2: got %h want %h", niu_sii_data, beats[2]); else passCnt++;
    rst_l = 1'b0;
    tick();
    mOq = DEPTH; mBq = DEPTH; mErr = 1'b0;
    totalCnt++; if ({niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq, niu_sii_datareq16, credit_err, pld_rdy, req_rdy} !== 7'b0000001)
      $display("[TB] FAIL mid_ctl: got %b want 0000001", {niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq, niu_sii_datareq16, credit_err, pld_rdy, req_rdy}); else passCnt++;
    totalCnt++; if ({niu_sii_data, niu_sii_parity, niu_sii_be} !== '0) $display("[TB] FAIL mid_data: got %h want 0", niu_sii_data); else passCnt++;
    totalCnt++; if ({dut.u_oq.avail, dut.u_bq.avail} !== {5'(mOq), 5'(mBq)})
      $display("[TB] FAIL mid_credits: got %0d/%0d want %0d/%0d", dut.u_oq.avail, dut.u_bq.avail, mOq, mBq); else passCnt++;
    rst_l = 1'b1;
    repeat (6) begin tick(); if (niu_sii_hdr_vld || niu_sii_data !== '0) stray++; end
    totalCnt++; if (stray != 0) $display("[TB] FAIL mid_no_tail: got %0d want 0", stray); else passCnt++;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_credit_stall();
    test_simultaneous();
    test_credit_err();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
